// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: final pipeline stage. It holds one instruction from the
// memory-access stage, selects its result, writes it to the register file once,
// offers that result for forwarding to decode, and counts retired instructions.
module reg_writeback_unit #(
   parameter int INSTR_WIDTH = 32,
   parameter int ADDR_WIDTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ma_valid,
   output logic                   ma_ready,
   input  logic                   ma_is_wb,
   input  logic                   ma_is_ld,
   input  logic                   ma_is_call,
   input  logic [ADDR_WIDTH-1:0]  ma_rd,
   input  logic [INSTR_WIDTH-1:0] ma_alu_result,
   input  logic [INSTR_WIDTH-1:0] ma_ld_result,
   input  logic [INSTR_WIDTH-1:0] ma_pc,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [ADDR_WIDTH-1:0]  dec_rs1,
   input  logic [ADDR_WIDTH-1:0]  dec_rs2,
   output logic                   wb_en,
   output logic [ADDR_WIDTH-1:0]  wb_addr,
   output logic [INSTR_WIDTH-1:0] wb_result,
   output logic                   fw_rs1_conflict,
   output logic                   fw_rs2_conflict,
   output logic [INSTR_WIDTH-1:0] fw_result,
   output logic [INSTR_WIDTH-1:0] retire_cnt
);

   // The link register is the highest-numbered register.
   localparam logic [ADDR_WIDTH-1:0] LinkReg = {ADDR_WIDTH{1'b1}};

   logic                   held_valid;
   logic                   held_is_wb;
   logic [ADDR_WIDTH-1:0]  held_rd;
   logic [INSTR_WIDTH-1:0] held_result;
   logic                   written;

   logic [INSTR_WIDTH-1:0] sel_result;
   logic [ADDR_WIDTH-1:0]  sel_rd;

   // Result and destination that would be captured this cycle: calls write the
   // return address to the link register, loads write load data, others the ALU value.
   always_comb begin
      sel_result = ma_alu_result;
      sel_rd     = ma_rd;
      if (ma_is_call) begin
         sel_result = ma_pc + INSTR_WIDTH'(4);
         sel_rd     = LinkReg;
      end else if (ma_is_ld) begin
         sel_result = ma_ld_result;
      end
   end

   // Stage register, written flag and retire counter. A stall freezes the stage
   // (flush included); the written flag keeps a stalled instruction from writing twice.
   always_ff @(posedge clk) begin
      if (rst) begin
         held_valid  <= 1'b0;
         held_is_wb  <= 1'b0;
         held_rd     <= '0;
         held_result <= '0;
         written     <= 1'b0;
         retire_cnt  <= '0;
      end else if (!stall) begin
         held_valid  <= ma_valid & ~flush;
         held_is_wb  <= ma_is_wb;
         held_rd     <= sel_rd;
         held_result <= sel_result;
         written     <= 1'b0;
         if (held_valid) begin
            retire_cnt <= retire_cnt + INSTR_WIDTH'(1);
         end
      end else if (wb_en) begin
         written <= 1'b1;
      end
   end

   // Register-file write port, forwarding and handshake, all derived from the stage register.
   always_comb begin
      ma_ready        = ~stall;
      wb_en           = held_valid & held_is_wb & ~written;
      wb_addr         = held_valid ? held_rd : '0;
      wb_result       = held_valid ? held_result : '0;
      fw_rs1_conflict = held_valid & held_is_wb & (dec_rs1 == wb_addr);
      fw_rs2_conflict = held_valid & held_is_wb & (dec_rs2 == wb_addr);
      fw_result       = wb_result;
   end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Testbench for reg_writeback_unit: directed vector table plus hand-written
// sequences for stall, reset mid-stall and retire-counter wrap.
module tb_reg_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ma_valid, ma_ready, ma_is_wb, ma_is_ld, ma_is_call;
   logic [3:0]  ma_rd, dec_rs1, dec_rs2, wb_addr;
   logic [31:0] ma_alu_result, ma_ld_result, ma_pc;
   logic        stall, flush, wb_en, fw_rs1_conflict, fw_rs2_conflict;
   logic [31:0] wb_result, fw_result, retire_cnt;

   // Narrow-datapath instance used to reach the counter wrap quickly
   logic        w_rst, w_valid, w_ready, w_en, w_c1, w_c2;
   logic [3:0]  w_addr;
   logic [7:0]  w_result, w_fw, w_cnt;

   int checksDone = 0;
   int failCount  = 0;

   typedef struct {
      logic        stall, flush, valid, is_wb, is_ld, is_call;
      logic [3:0]  rd;
      logic [31:0] alu, ld, pc;
      logic [3:0]  rs1, rs2;
      logic        e_en;
      logic [3:0]  e_addr;
      logic [31:0] e_res;
      logic        e_c1, e_c2;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs[11];

   reg_writeback_unit dut (
      .clk(clk), .rst(rst),
      .ma_valid(ma_valid), .ma_ready(ma_ready),
      .ma_is_wb(ma_is_wb), .ma_is_ld(ma_is_ld), .ma_is_call(ma_is_call),
      .ma_rd(ma_rd), .ma_alu_result(ma_alu_result), .ma_ld_result(ma_ld_result),
      .ma_pc(ma_pc), .stall(stall), .flush(flush),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_result(wb_result),
      .fw_rs1_conflict(fw_rs1_conflict), .fw_rs2_conflict(fw_rs2_conflict),
      .fw_result(fw_result), .retire_cnt(retire_cnt)
   );

   reg_writeback_unit #(.INSTR_WIDTH(8), .ADDR_WIDTH(4)) dut_w8 (
      .clk(clk), .rst(w_rst),
      .ma_valid(w_valid), .ma_ready(w_ready),
      .ma_is_wb(1'b1), .ma_is_ld(1'b0), .ma_is_call(1'b0),
      .ma_rd(4'd1), .ma_alu_result(8'h5), .ma_ld_result(8'h0),
      .ma_pc(8'h0), .stall(1'b0), .flush(1'b0),
      .dec_rs1(4'd0), .dec_rs2(4'd0),
      .wb_en(w_en), .wb_addr(w_addr), .wb_result(w_result),
      .fw_rs1_conflict(w_c1), .fw_rs2_conflict(w_c2),
      .fw_result(w_fw), .retire_cnt(w_cnt)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checksDone++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      stall         = v.stall;
      flush         = v.flush;
      ma_valid      = v.valid;
      ma_is_wb      = v.is_wb;
      ma_is_ld      = v.is_ld;
      ma_is_call    = v.is_call;
      ma_rd         = v.rd;
      ma_alu_result = v.alu;
      ma_ld_result  = v.ld;
      ma_pc         = v.pc;
      dec_rs1       = v.rs1;
      dec_rs2       = v.rs2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAll(input string tag, input logic en, input logic [3:0] addr,
                           input logic [31:0] res, input logic c1, input logic c2,
                           input logic [31:0] cnt, input logic rdy);
      checkOutput({tag, ".wb_en"}, 32'(wb_en), 32'(en));
      checkOutput({tag, ".wb_addr"}, 32'(wb_addr), 32'(addr));
      checkOutput({tag, ".wb_result"}, wb_result, res);
      checkOutput({tag, ".fw_result"}, fw_result, res);
      checkOutput({tag, ".fw_rs1"}, 32'(fw_rs1_conflict), 32'(c1));
      checkOutput({tag, ".fw_rs2"}, 32'(fw_rs2_conflict), 32'(c2));
      checkOutput({tag, ".retire_cnt"}, retire_cnt, cnt);
      checkOutput({tag, ".ma_ready"}, 32'(ma_ready), 32'(rdy));
   endtask

   initial begin
      // stall flush valid wb ld call rd alu ld pc rs1 rs2 | en addr res c1 c2 cnt
      vecs[0]  = '{0,0,1,1,0,0, 4'd3, 32'h2A, 32'h0, 32'h0, 4'd3, 4'd0,  1, 4'd3,  32'h2A,       1,0, 32'd0};
      vecs[1]  = '{0,0,0,0,0,0, 4'd0, 32'h0,  32'h0, 32'h0, 4'd3, 4'd0,  0, 4'd0,  32'h0,        0,0, 32'd1};
      vecs[2]  = '{0,0,1,1,0,1, 4'd7, 32'h9,  32'h0, 32'h100, 4'd15, 4'd7, 1, 4'd15, 32'h104,   1,0, 32'd1};
      vecs[3]  = '{0,0,1,1,1,0, 4'd2, 32'h99, 32'h55, 32'h0, 4'd2, 4'd2,  1, 4'd2,  32'h55,       1,1, 32'd2};
      vecs[4]  = '{0,0,1,0,0,0, 4'd4, 32'h77, 32'h0, 32'h0, 4'd4, 4'd4,  0, 4'd4,  32'h77,       0,0, 32'd3};
      vecs[5]  = '{0,0,1,1,0,0, 4'd4, 32'h11, 32'h0, 32'h0, 4'd4, 4'd4,  1, 4'd4,  32'h11,       1,1, 32'd4};
      vecs[6]  = '{0,1,1,1,0,0, 4'd9, 32'h88, 32'h0, 32'h0, 4'd9, 4'd9,  0, 4'd0,  32'h0,        0,0, 32'd5};
      vecs[7]  = '{0,0,0,0,0,0, 4'd0, 32'h0,  32'h0, 32'h0, 4'd0, 4'd0,  0, 4'd0,  32'h0,        0,0, 32'd5};
      vecs[8]  = '{0,0,1,1,1,1, 4'd1, 32'h44, 32'h33, 32'hFFFF_FFFE, 4'd1, 4'd15, 1, 4'd15, 32'h2, 0,1, 32'd5};
      vecs[9]  = '{0,0,1,1,0,0, 4'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'd0, 4'd5, 1, 4'd0, 32'hDEAD_BEEF, 1,0, 32'd6};
      vecs[10] = '{0,0,0,0,0,0, 4'd0, 32'h0,  32'h0, 32'h0, 4'd0, 4'd0,  0, 4'd0,  32'h0,        0,0, 32'd7};

      // Reset with stall asserted: all outputs clear, ready follows stall
      rst = 1'b1;
      w_rst = 1'b1;
      w_valid = 1'b0;
      applyStimulus(vecs[7]);
      stall = 1'b1;
      flush = 1'b1;
      tick();
      tick();
      checkAll("reset", 0, 4'd0, 32'h0, 0, 0, 32'd0, 0);
      rst = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      #1;
      checkOutput("reset.ma_ready_unstalled", 32'(ma_ready), 32'd1);

      // Directed vector table
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkAll($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_addr, vecs[i].e_res,
                  vecs[i].e_c1, vecs[i].e_c2, vecs[i].e_cnt, ~vecs[i].stall);
      end

      // Stall for 3 cycles: single write, forwarding held, counter frozen, flush ignored
      applyStimulus(vecs[7]);
      ma_valid = 1'b1; ma_is_wb = 1'b1; ma_rd = 4'd5; ma_alu_result = 32'h5A; dec_rs1 = 4'd5;
      tick();
      stall = 1'b1;
      ma_valid = 1'b0;
      #1;
      checkAll("stall.first", 1, 4'd5, 32'h5A, 1, 0, 32'd7, 0);
      for (int s = 0; s < 3; s++) begin
         flush = (s == 1);
         ma_valid = (s == 2);
         tick();
         checkAll($sformatf("stall.c%0d", s), 0, 4'd5, 32'h5A, 1, 0, 32'd7, 0);
      end
      stall = 1'b0;
      flush = 1'b0;
      ma_valid = 1'b0;
      tick();
      checkAll("stall.release", 0, 4'd0, 32'h0, 0, 0, 32'd8, 1);

      // Reset while a stalled instruction is pending: it is dropped without writing
      ma_valid = 1'b1; ma_is_wb = 1'b1; ma_rd = 4'd6; ma_alu_result = 32'h66; dec_rs1 = 4'd6;
      tick();
      checkAll("rststall.capture", 1, 4'd6, 32'h66, 1, 0, 32'd8, 1);
      stall = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      checkAll("rststall.reset", 0, 4'd0, 32'h0, 0, 0, 32'd0, 0);
      rst = 1'b0;
      stall = 1'b0;
      ma_valid = 1'b0;
      tick();
      checkAll("rststall.after", 0, 4'd0, 32'h0, 0, 0, 32'd0, 1);

      // Retire-counter wrap on the 8-bit instance: 256 accepting edges give 255, one more gives 0
      w_rst = 1'b0;
      w_valid = 1'b1;
      repeat (256) tick();
      checkOutput("wrap.all_ones", 32'(w_cnt), 32'd255);
      tick();
      checkOutput("wrap.zero", 32'(w_cnt), 32'd0);
      checkOutput("wrap.wb_en", 32'(w_en), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checksDone, failCount);
      $finish;
   end

endmodule

// File: doc/reg_writeback_unit.md
REG_WRITEBACK_UNIT -- requirements
Module: reg_writeback_unit

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32, data width of results, PC and retire counter.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register address width (16 registers).
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 SHALL have ports, in this order:
 clk  in  1  clock
 rst  in  1  sync active-high reset
 ma_valid  in  1  memory-access stage presents an instruction
 ma_ready  out  1  stage accepts this cycle
 ma_is_wb  in  1  instruction writes a register
 ma_is_ld  in  1  result comes from load data
 ma_is_call  in  1  call: result is return address
 ma_rd  in  ADDR_WIDTH  destination register
 ma_alu_result  in  INSTR_WIDTH  ALU result
 ma_ld_result  in  INSTR_WIDTH  load data
 ma_pc  in  INSTR_WIDTH  instruction PC
 stall  in  1  freeze stage
 flush  in  1  squash incoming instruction
 dec_rs1  in  ADDR_WIDTH  decode source 1 address
 dec_rs2  in  ADDR_WIDTH  decode source 2 address
 wb_en  out  1  register-file write enable (isWb)
 wb_addr  out  ADDR_WIDTH  register-file write address
 wb_result  out  INSTR_WIDTH  register-file write data
 fw_rs1_conflict  out  1  forward wb_result to operand 1
 fw_rs2_conflict  out  1  forward wb_result to operand 2
 fw_result  out  INSTR_WIDTH  forwarded value
 retire_cnt  out  INSTR_WIDTH  retired instruction count

Function
REQ-005 SHALL hold one instruction in a stage register (held_valid, is_wb, rd, selected result) plus a written flag.
REQ-006 SHALL drive ma_ready = !stall, combinationally.
REQ-007 SHALL, at an edge with !stall, load held_valid <= ma_valid & !flush, capture fields, clear written.
REQ-008 SHALL, at an edge with stall, keep all stage-register contents; flush has no effect while stalled.
REQ-009 SHALL select result at capture with priority: is_call -> ma_pc+4 (mod 2^INSTR_WIDTH); else is_ld -> ma_ld_result; else ma_alu_result.
REQ-010 SHALL force captured address to 15 when is_call, ignoring ma_rd; otherwise ma_rd.
REQ-011 SHALL drive wb_en = held_valid & is_wb & !written, so each instruction writes exactly once.
REQ-012 SHALL set written at an edge where wb_en=1 and stall=1.
REQ-013 SHALL drive wb_addr/wb_result from the stage register when held_valid=1, else 0.
REQ-014 SHALL drive fw_rs1_conflict = held_valid & is_wb & (dec_rs1 == wb_addr), combinationally; same for rs2; written does not mask.
REQ-015 SHALL drive fw_result = wb_result.
REQ-016 SHALL increment retire_cnt at every edge with held_valid=1 and stall=0, including non-writing instructions.
REQ-017 SHALL wrap retire_cnt from all-ones to 0.
REQ-018 SHALL impose one-cycle latency from ma_valid capture to wb_en.
REQ-019 SHALL allow back-to-back acceptance at one instruction per cycle when stall=0.

Reset
REQ-020 SHALL, at an edge with rst=1, clear held_valid, written, the stage register and retire_cnt to 0, overriding stall and flush.
REQ-021 SHALL therefore output wb_en=0, wb_addr=0, wb_result=0, fw_*_conflict=0, fw_result=0, retire_cnt=0 after reset; ma_ready still follows stall.
REQ-022 SHALL discard an in-flight instruction on reset mid-stall without writing it.

Verification
REQ-023 ALU op: ma_valid=1, is_wb=1, rd=3, alu=0x2A -> next cycle wb_en=1, wb_addr=3, wb_result=0x2A; retire_cnt 0->1 the following edge.
REQ-024 Call: is_call=1, is_wb=1, pc=0x100, rd=7 -> wb_addr=15, wb_result=0x104; load with is_ld=1, ld=0x55 -> wb_result=0x55.
REQ-025 Stall: capture rd=5 then stall=1 for 3 cycles -> wb_en high 1 cycle only, fw_rs1_conflict=1 throughout with dec_rs1=5, retire_cnt unchanged until stall drops.
REQ-026 Flush: ma_valid=1, flush=1, stall=0 -> held_valid=0, no wb_en, retire_cnt unchanged; flush=1 with stall=1 -> held instruction kept.
REQ-027 Forwarding: held rd=4, is_wb=1, dec_rs1=4, dec_rs2=4 -> both conflicts 1; is_wb=0 -> both 0.
REQ-028 Counter wrap: force retire_cnt=0xFFFFFFFF, retire one -> 0; rst mid-stall -> all outputs 0 next cycle.
